serial_slave_port_p: RTL and testbench
======================================

// Module: serial_slave_port_p
// PURPOSE
//  Parametrised serial bus slave port: next generation of the system-bus slave interface.
//  Receives a bit-serial address and write data from a master and issues memory-side
//  write/read strobes. Serialises read data back to the master.
//  Adds generic widths, multi-beat bursts with address auto-increment, valid/ready stalling
//  and a memory-side read request. Sits between the bus interconnect and a slave memory/peripheral.
// PARAMETERS
//  ADDR_W  12  address width (bits shifted on rx_address)
//  DATA_W  8   data word width
//  BLEN_W  4   width of burst_len; beats per transaction = burst_len+1 (1..2^BLEN_W)
// PORTS
//  clk           in   1       single clock, all logic on rising edge
//  reset         in   1       synchronous, active-low reset
//  read_en       in   1       read command, sampled in IDLE with master_valid
//  write_en      in   1       write command, sampled in IDLE with master_valid
//  burst_len     in   BLEN_W  beats-1, sampled with command
//  master_valid  in   1       master drives valid serial bit this cycle
//  master_ready  in   1       master accepts tx_data bit this cycle
//  rx_address    in   1       serial address bit, LSB first
//  rx_data       in   1       serial write-data bit, LSB first
//  slave_ready   out  1       1 only in IDLE (command may be issued)
//  slave_valid   out  1       tx_data holds a valid read bit
//  tx_data       out  1       serial read-data bit, LSB first
//  rx_done       out  1       1-cycle pulse per completed write beat
//  slave_tx_done out  1       1-cycle pulse after last bit of each read beat accepted
//  address       out  ADDR_W  current beat address to memory
//  data          out  DATA_W  write data to memory, held until next write beat
//  mem_write     out  1       1-cycle write strobe, address/data valid same cycle
//  mem_read      out  1       1-cycle read request for address
//  data_ready    in   1       datain valid (read response)
//  datain        in   DATA_W  read data from memory
// BEHAVIOUR
//  Reset (reset=0 at edge): state IDLE. slave_ready=1; address, data and all other outputs 0.
//   Beat counter cleared. Reset wins over every other event, including mid-burst; no strobe is emitted.
//  FSM: IDLE -> RX_ADDR -> {RX_DATA -> WR_BEAT | RD_REQ -> RD_WAIT -> TX} -> next beat or IDLE.
//  IDLE: master_valid & (read_en ^ write_en) -> latch mode and burst_len, go RX_ADDR.
//   Both enables high, or neither -> ignored, stay IDLE.
//  RX_ADDR: shift rx_address in only on cycles with master_valid=1 (otherwise hold).
//   After ADDR_W sampled bits, drive address. Write -> RX_DATA; read -> RD_REQ.
//  RX_DATA: shift rx_data on master_valid=1 for DATA_W bits, then WR_BEAT.
//  WR_BEAT (1 cycle): mem_write=1, rx_done=1, data=assembled word.
//   Beats remain -> address+1 (mod 2^ADDR_W, FFF->000 wraps), go RX_DATA; else IDLE.
//  Latency, no stalls: command accepted cycle 0; mem_write in cycle ADDR_W+DATA_W+1.
//  RD_REQ (1 cycle): mem_read=1 -> RD_WAIT.
//  RD_WAIT: wait unbounded for data_ready; on it, load datain into shifter -> TX.
//   data_ready outside RD_WAIT is ignored.
//  TX: slave_valid=1, tx_data=shifter LSB. Shift only on cycles with master_ready=1;
//   bit held otherwise. After DATA_W accepted bits: slave_tx_done pulse,
//   next beat (address+1, RD_REQ) or IDLE. slave_valid=0 outside TX.
//  Counters: bit counter clog2(max(ADDR_W,DATA_W)+1) bits; beat counter BLEN_W bits, down-count to 0.
// STRUCTURE
//  Shared include system_bus_defs.vh: FSM state localparams, MODE_RD/MODE_WR encodings,
//   default ADDR_W/DATA_W.
//  One sub-module bus_shift_reg #(W): loadable LSB-first shift register with shift enable.
//   Instantiated as SIPO for address, SIPO for write data, PISO for read data.
// TESTING (ADDR_W=12, DATA_W=8)
//  1 Write, burst_len=0, addr 0x0A5, data 0x3C, master_valid steady ->
//    mem_write, rx_done high at cycle 21 only; address=0x0A5, data=0x3C; then slave_ready=1.
//  2 Write burst_len=2 at 0xFFF, data 0x11,0x22,0x33 ->
//    three mem_write pulses at addresses 0xFFF, 0x000, 0x001 with matching data.
//  3 Read addr 0x010, data_ready 3 cycles after mem_read with datain 0xA6, master_ready=1 ->
//    tx_data 0,1,1,0,0,1,0,1; slave_tx_done once.
//  4 Test 3 with master_ready low 4 cycles after bit 2 -> bit 2 held 5 cycles, still exactly 8 bits.
//  5 read_en=write_en=1 with master_valid -> no transition, slave_ready stays 1.
//    master_valid low 3 cycles mid-address -> mem_write delayed by exactly 3 cycles.
//  6 reset=0 during beat 2 of a 3-beat write ->
//    next cycle IDLE, slave_ready=1, no further mem_write or rx_done.

Source files
------------

// File: rtl/serial_slave_port_p_pkg.sv
// Shared types and constants for the serial slave port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, command mode encoding, default widths and
//   a helper sizing the shared bit counter.
package serial_slave_port_p_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_ADDR = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_WR_BEAT = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_TX      = 3'd6
  } state_e;

  typedef enum logic {
    MODE_RD = 1'b0,
    MODE_WR = 1'b1
  } mode_e;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_BLEN_W = 4;

  // One counter serves both address and data phases, so it must reach
  // the larger of the two widths.
  function automatic int cnt_w(input int aw, input int dw);
    return $clog2(((aw > dw) ? aw : dw) + 1);
  endfunction

endpackage

// File: rtl/serial_slave_port_p_shift_reg.sv
// Loadable LSB-first shift register (SIPO or PISO depending on use).
// Latency: parallel load or one shift per clock with shift_en.
// Backpressure: none; holds contents whenever load and shift_en are low.
// Ports: clk, reset (sync, active-low), load/load_val (parallel load, wins
//   over shift), shift_en/ser_in (new bit enters the MSB, contents move
//   toward the LSB), q (current contents).
module serial_slave_port_p_shift_reg
  import serial_slave_port_p_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // After W shifts the first bit received sits in bit 0, so serial data
  // sent LSB first lands in natural bit order.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = {ser_in, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/serial_slave_port_p.sv
// Serial bus slave port: bit-serial address/write data in, memory strobes
//   out, read data serialised back; bursts with address auto-increment.
// Latency: command at cycle 0 -> mem_write at cycle ADDR_W+DATA_W+1 with no stalls.
// Backpressure: master_valid low freezes rx shifting, master_ready low holds
//   the current tx bit, RD_WAIT waits indefinitely for data_ready.
// Ports: clk, reset (sync, active-low); command read_en/write_en/burst_len
//   with master_valid; serial rx_address/rx_data in, tx_data/slave_valid out
//   (master_ready accepts); slave_ready (idle), rx_done/slave_tx_done beat
//   pulses; memory side address/data/mem_write/mem_read, datain/data_ready.
module serial_slave_port_p
  import serial_slave_port_p_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BLEN_W = DEF_BLEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [BLEN_W-1:0] burst_len,
  input  logic              master_valid,
  input  logic              master_ready,
  input  logic              rx_address,
  input  logic              rx_data,
  output logic              slave_ready,
  output logic              slave_valid,
  output logic              tx_data,
  output logic              rx_done,
  output logic              slave_tx_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] datain
);

  localparam int CNT_W = cnt_w(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BLEN_W-1:0]   beat_q, beat_d;
  logic                addr_vld_q, addr_vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tx_done_q, tx_done_d;

  logic                addr_shift, addr_load;
  logic                wd_shift;
  logic                rd_load, rd_shift;
  logic [ADDR_W-1:0]   addr_word;
  logic [DATA_W-1:0]   wd_word;
  logic [DATA_W-1:0]   rd_word;

  // The address shifter doubles as the beat address register: it is
  // reloaded with address+1 between beats, wrapping naturally at 2^ADDR_W.
  serial_slave_port_p_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load),
    .load_val (addr_word + 1'b1),
    .shift_en (addr_shift),
    .ser_in   (rx_address),
    .q        (addr_word)
  );

  serial_slave_port_p_shift_reg #(.W(DATA_W)) u_wdata_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (wd_shift),
    .ser_in   (rx_data),
    .q        (wd_word)
  );

  serial_slave_port_p_shift_reg #(.W(DATA_W)) u_rdata_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_load),
    .load_val (datain),
    .shift_en (rd_shift),
    .ser_in   (1'b0),
    .q        (rd_word)
  );

  // Only the LSB of the read shifter is ever presented on the wire.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_word[DATA_W-1:1];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    addr_vld_d  = addr_vld_q;
    data_d      = data_q;
    tx_done_d   = 1'b0;
    addr_shift  = 1'b0;
    addr_load   = 1'b0;
    wd_shift    = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    rx_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        slave_ready = 1'b1;
        // Exactly one enable must be set; both or neither is not a command.
        if (master_valid && (read_en ^ write_en)) begin
          mode_d     = write_en ? MODE_WR : MODE_RD;
          beat_d     = burst_len;
          cnt_d      = '0;
          addr_vld_d = 1'b0;
          state_d    = ST_RX_ADDR;
        end
      end

      ST_RX_ADDR: begin
        if (master_valid) begin
          addr_shift = 1'b1;
          if (cnt_q == LAST_A) begin
            cnt_d      = '0;
            addr_vld_d = 1'b1;
            state_d    = (mode_q == MODE_WR) ? ST_RX_DATA : ST_RD_REQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RX_DATA: begin
        if (master_valid) begin
          wd_shift = 1'b1;
          if (cnt_q == LAST_D) begin
            cnt_d   = '0;
            state_d = ST_WR_BEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WR_BEAT: begin
        mem_write = 1'b1;
        rx_done   = 1'b1;
        data_d    = wd_word;
        if (beat_q != '0) begin
          beat_d    = beat_q - 1'b1;
          addr_load = 1'b1;
          state_d   = ST_RX_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        mem_read = 1'b1;
        state_d  = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (data_ready) begin
          rd_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_TX;
        end
      end

      ST_TX: begin
        slave_valid = 1'b1;
        if (master_ready) begin
          rd_shift = 1'b1;
          if (cnt_q == LAST_D) begin
            cnt_d     = '0;
            tx_done_d = 1'b1;
            if (beat_q != '0) begin
              beat_d    = beat_q - 1'b1;
              addr_load = 1'b1;
              state_d   = ST_RD_REQ;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RD;
      cnt_q      <= '0;
      beat_q     <= '0;
      addr_vld_q <= 1'b0;
      data_q     <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      addr_vld_q <= addr_vld_d;
      data_q     <= data_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Address reads as zero while a new one is being shifted in.
  assign address       = addr_vld_q ? addr_word : '0;
  // The assembled word is shown in the strobe cycle itself, then held.
  assign data          = (state_q == ST_WR_BEAT) ? wd_word : data_q;
  assign tx_data       = (state_q == ST_TX) & rd_word[0];
  assign slave_tx_done = tx_done_q;

endmodule

// File: tb/tb_serial_slave_port_p.sv
`timescale 1ns/1ps
module tb_serial_slave_port_p;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_en = 1'b0, write_en = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          master_valid = 1'b0, master_ready = 1'b0;
  logic          rx_address = 1'b0, rx_data = 1'b0;
  logic          data_ready = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          slave_ready, slave_valid, tx_data, rx_done, slave_tx_done;
  logic          mem_write, mem_read;
  logic [AW-1:0] address;
  logic [DW-1:0] data;

  serial_slave_port_p #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .burst_len(burst_len), .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_data(rx_data), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .tx_data(tx_data), .rx_done(rx_done),
    .slave_tx_done(slave_tx_done), .address(address), .data(data),
    .mem_write(mem_write), .mem_read(mem_read), .data_ready(data_ready),
    .datain(datain)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int mw_cnt = 0;
  int mw_cyc = 0;
  int txd_cnt = 0;

  logic [AW+DW-1:0] wr_exp[$];
  logic [AW-1:0]    rd_exp[$];
  logic             bit_exp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", msg);
  endtask

  // Monitor: pops scoreboard queues whenever the DUT presents a transfer.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic             b;
    if (rx_done !== mem_write) fail($sformatf("rx_done_vs_mem_write: rx_done %0b mem_write %0b", rx_done, mem_write));
    if (mem_write === 1'b1) begin
      mw_cnt++;
      mw_cyc = cyc;
      if (wr_exp.size() == 0) begin
        fail($sformatf("unexpected_mem_write: address %0h data %0h, none expected", address, data));
      end else begin
        e = wr_exp.pop_front();
        chk("wr_address", 64'(address), 64'(e[AW+DW-1:DW]));
        chk("wr_data", 64'(data), 64'(e[DW-1:0]));
      end
    end
    if (mem_read === 1'b1) begin
      if (rd_exp.size() == 0) fail($sformatf("unexpected_mem_read: address %0h", address));
      else chk("rd_address", 64'(address), 64'(rd_exp.pop_front()));
    end
    if (slave_valid === 1'b1 && master_ready === 1'b1) begin
      if (bit_exp.size() == 0) begin
        fail($sformatf("unexpected_tx_bit: %0b", tx_data));
      end else begin
        b = bit_exp.pop_front();
        chk("tx_bit", 64'(tx_data), 64'(b));
      end
    end
    if (slave_tx_done === 1'b1) txd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic rd, input logic wr, input logic [BW-1:0] bl, output int c0);
    read_en = rd; write_en = wr; burst_len = bl; master_valid = 1'b1;
    tick();
    c0 = cyc;
    read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n, input logic is_addr,
                      input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        master_valid = 1'b0;
        repeat (stall_len) tick();
      end
      master_valid = 1'b1;
      if (is_addr) rx_address = v[i];
      else         rx_data    = v[i];
      tick();
    end
    master_valid = 1'b0;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return mem_read;
      1:       return slave_tx_done;
      default: return slave_valid;
    endcase
  endfunction

  // Returns at the negedge where the selected signal is seen high.
  task automatic wait_for(input int w, input string name);
    int k = 0;
    @(negedge clk);
    while (sel(w) !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail($sformatf("timeout_%s: event not seen within 200 cycles", name));
  endtask

  task automatic push_bits(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) bit_exp.push_back(d[i]);
  endtask

  // Answer the next mem_read with d, dly cycles after the request cycle.
  task automatic read_beat(input logic [DW-1:0] d, input int dly);
    wait_for(0, "mem_read");
    @(posedge clk); #1;
    repeat (dly - 1) tick();
    data_ready = 1'b1; datain = d;
    tick();
    data_ready = 1'b0; datain = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, m0, t0;
    logic [DW-1:0] wd [3];

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("reset_slave_ready", 64'(slave_ready), 64'd1);
    chk("reset_address", 64'(address), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    chk("reset_strobes", 64'({slave_valid, tx_data, rx_done, slave_tx_done, mem_write, mem_read}), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single write, latency check
    wr_exp.push_back({12'h0A5, 8'h3C});
    m0 = mw_cnt;
    cmd(1'b0, 1'b1, 4'd0, c0);
    send(16'h0A5, AW, 1'b1, -1, 0);
    send(16'h003C, DW, 1'b0, -1, 0);
    tick();
    chk("t1_write_count", 64'(mw_cnt - m0), 64'd1);
    chk("t1_write_cycle", 64'(mw_cyc - c0 + 1), 64'd21);
    @(negedge clk);
    chk("t1_ready_after", 64'(slave_ready), 64'd1);
    @(posedge clk); #1;

    // 2: 3-beat write burst wrapping at the top of the address space
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    wr_exp.push_back({12'hFFF, 8'h11});
    wr_exp.push_back({12'h000, 8'h22});
    wr_exp.push_back({12'h001, 8'h33});
    m0 = mw_cnt;
    cmd(1'b0, 1'b1, 4'd2, c0);
    send(16'hFFF, AW, 1'b1, -1, 0);
    for (int b = 0; b < 3; b++) begin
      send({8'h00, wd[b]}, DW, 1'b0, -1, 0);
      tick();
    end
    chk("t2_write_count", 64'(mw_cnt - m0), 64'd3);

    // 3: single read, master always ready
    master_ready = 1'b1;
    rd_exp.push_back(12'h010);
    push_bits(8'hA6);
    t0 = txd_cnt;
    cmd(1'b1, 1'b0, 4'd0, c0);
    send(16'h010, AW, 1'b1, -1, 0);
    read_beat(8'hA6, 3);
    wait_for(1, "t3_tx_done");
    @(posedge clk); #1;
    chk("t3_tx_done_count", 64'(txd_cnt - t0), 64'd1);
    chk("t3_bits_left", 64'(bit_exp.size()), 64'd0);
    chk("t3_idle_ready", 64'(slave_ready), 64'd1);

    // 4: same read, master stalls 4 cycles on bit 2
    rd_exp.push_back(12'h010);
    push_bits(8'hA6);
    t0 = txd_cnt;
    cmd(1'b1, 1'b0, 4'd0, c0);
    send(16'h010, AW, 1'b1, -1, 0);
    read_beat(8'hA6, 3);
    tick();
    tick();
    master_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("t4_bit2_held", 64'({slave_valid, tx_data}), 64'b11);
      @(posedge clk); #1;
    end
    master_ready = 1'b1;
    wait_for(1, "t4_tx_done");
    @(posedge clk); #1;
    chk("t4_tx_done_count", 64'(txd_cnt - t0), 64'd1);
    chk("t4_bits_left", 64'(bit_exp.size()), 64'd0);

    // 5a: ambiguous or empty commands are ignored
    read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1;
    tick();
    read_en = 1'b0; write_en = 1'b0;
    @(negedge clk);
    chk("t5_both_enables_ready", 64'(slave_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_no_enable_ready", 64'(slave_ready), 64'd1);
    @(posedge clk); #1;
    master_valid = 1'b0;

    // 5b: master_valid low 3 cycles mid-address delays the write by 3
    wr_exp.push_back({12'h5A3, 8'hC7});
    m0 = mw_cnt;
    cmd(1'b0, 1'b1, 4'd0, c0);
    send(16'h5A3, AW, 1'b1, 5, 3);
    send(16'h00C7, DW, 1'b0, -1, 0);
    tick();
    chk("t5_write_count", 64'(mw_cnt - m0), 64'd1);
    chk("t5_write_cycle", 64'(mw_cyc - c0 + 1), 64'd24);

    // 6: reset in beat 2 of a 3-beat write
    wr_exp.push_back({12'h100, 8'h44});
    m0 = mw_cnt;
    cmd(1'b0, 1'b1, 4'd2, c0);
    send(16'h100, AW, 1'b1, -1, 0);
    send(16'h0044, DW, 1'b0, -1, 0);
    tick();
    send(16'h0099, 4, 1'b0, -1, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_reset", 64'(slave_ready), 64'd1);
    chk("t6_address_after_reset", 64'(address), 64'd0);
    chk("t6_data_after_reset", 64'(data), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      master_valid = 1'b1;
      rx_data = i[0];
      rx_address = i[1];
      tick();
    end
    master_valid = 1'b0;
    chk("t6_write_count", 64'(mw_cnt - m0), 64'd1);

    // 7: 2-beat read burst wrapping at 0xFFF; stray data_ready ignored
    rd_exp.push_back(12'hFFF);
    rd_exp.push_back(12'h000);
    push_bits(8'h5A);
    push_bits(8'h81);
    t0 = txd_cnt;
    cmd(1'b1, 1'b0, 4'd1, c0);
    data_ready = 1'b1; datain = 8'hFF;
    send(16'hFFF, AW, 1'b1, -1, 0);
    data_ready = 1'b0; datain = '0;
    read_beat(8'h5A, 1);
    read_beat(8'h81, 2);
    wait_for(1, "t7_tx_done");
    @(posedge clk); #1;
    chk("t7_tx_done_count", 64'(txd_cnt - t0), 64'd2);

    repeat (5) tick();
    chk("end_writes_left", 64'(wr_exp.size()), 64'd0);
    chk("end_reads_left", 64'(rd_exp.size()), 64'd0);
    chk("end_bits_left", 64'(bit_exp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
